pipelined_addsub: RTL
=====================

Name: pipelined_addsub

Overview:
Parametrised, fully pipelined wide-integer adder/subtractor for the ECDSA datapath. It generalises the fixed 384-bit, 3-stage carry-chained adder to any width and stage count, and adds a per-operation add/sub mode. It also adds a valid/ready handshake with backpressure, so it can sit directly between the operand sequencer and the modular-reduction unit. Sustained throughput is one operation per clock.

Parameters:
WIDTH, 384, operand width in bits; must be divisible by STAGES.
STAGES, 3, number of pipeline stages; limb width L = WIDTH/STAGES; legal range 1..8.

Ports:
clk  in  1  clock
resetn  in  1  reset
in_valid  in  1  operand beat present
in_ready  out  1  block accepts beat this cycle
sub  in  1  0: A+B+cin; 1: A-B (computed as A+~B+1; cin ignored)
cin  in  1  carry-in, add mode only
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
result  out  WIDTH+1  {carry_out, sum}; in sub mode carry_out=1 means no borrow (A>=B)

Behaviour:
- Reset: reset resetn, synchronous, active-low; clock clk. On reset every stage valid bit, data register and carry register clears; out_valid=0, result=0. in_ready=1 in the first cycle after reset.
- Advance: adv = ~out_valid | out_ready. All stages shift together when adv=1 and hold when adv=0.
- in_ready = adv, combinational. An input is accepted iff in_valid & in_ready.
- Stage k (0..STAGES-1) adds limb k of A and limb k of B' plus the carry from stage k-1.
  - B' = sub ? ~b : b.
  - Stage 0 carry-in = sub ? 1 : cin.
  - Each stage registers an (L+1)-bit sum.
- Skew buffers:
  - Limbs k+1..STAGES-1 of A and B', plus the resolved lower limbs, travel with the beat in delay registers.
  - Each limb's result emerges aligned in the final stage.
- Latency: exactly STAGES cycles from acceptance to out_valid when there is no stall.
  - Each cycle with adv=0 adds one cycle.
  - Outputs are registered directly from the last stage.
- Valid bits: one per stage, shifted with adv. A bubble (in_valid=0 while adv=1) inserts valid=0. Data registers may still load when valid=0, but result is only meaningful when out_valid=1.
- Ordering: results leave strictly in acceptance order. With out_ready held high, throughput is 1 result/cycle.
- Stall: when out_valid=1 and out_ready=0, result and out_valid hold stable. Every internal stage holds, and no beat is lost or duplicated.
- Wrap-around: the sum is modulo 2^WIDTH, and the carry is exposed in result[WIDTH].
  - Sub of equal operands gives result={1,0}.
  - Sub with A<B gives carry 0 and sum 2^WIDTH+A-B.
- Simultaneous accept and output in one cycle (full pipe, out_ready=1, in_valid=1) is legal and keeps the pipe full.
- Reset mid-operation: in-flight beats are discarded, and no out_valid pulse appears in the cycle after reset asserts.
- STAGES=1 degenerates to a single registered adder with latency 1.

Optional Feature:
Macro ADDSUB_ZERO_FLAG_EN.
- Defined: adds output port result_zero (1 bit).
  - Registered alongside result; equals 1 iff result[WIDTH-1:0]==0 and out_valid=1.
  - Computed incrementally as an AND of per-limb zero bits carried through the skew buffers, with no wide OR in the final stage.
  - Reset value 0; holds during stall.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. WIDTH=384, STAGES=3, add: a=2^384-1, b=1, cin=0, out_ready=1.
   - Required: out_valid exactly 3 cycles after accept, result={1,0}; with the flag enabled, result_zero=1.
2. Sub mode: a=5, b=7, then a=7, b=7.
   - Required: result={0, 2^384-2} then {1,0}, back to back on consecutive cycles.
3. Streaming: 20 random add/sub beats on consecutive cycles, out_ready=1.
   - Required: 20 consecutive out_valid cycles, in order, every result matching the reference model; in_ready constantly 1.
4. Backpressure: fill the pipe with 3 beats, hold out_ready=0 for 5 cycles, then release.
   - During the stall: in_ready=0, result stable.
   - After release: all 3 results, in order, one per cycle; no loss or duplication.
5. Reset mid-flight: accept 2 beats, assert resetn=0 for 1 cycle.
   - Required: out_valid=0 and result=0 after reset; the discarded beats never appear; a new beat afterwards emerges with latency 3.
6. Parameter sweep (WIDTH=256, STAGES=4; WIDTH=64, STAGES=1) with carry-propagating operands (all-ones + cin=1).
   - Required: correct carry across every limb boundary; latency equals STAGES.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Carry-chained wide adder/subtractor, one limb resolved per stage, valid/ready with backpressure.
// Optional ADDSUB_ZERO_FLAG_EN adds a registered result_zero output built from per-limb zero bits.
module pipelined_addsub #(
   parameter int WIDTH  = 384,
   parameter int STAGES = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef ADDSUB_ZERO_FLAG_EN
   output logic             result_zero,
`endif
   output logic [WIDTH:0]   result
);

   localparam int L = WIDTH / STAGES;

   // acc holds limbs already resolved; a/b carry the not-yet-consumed upper limbs
   logic [STAGES-1:0][WIDTH-1:0] acc_q, acc_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
   logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
   logic [STAGES-1:0]            carry_q, carry_d;
   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0][L:0]       limb_sum;
   logic [WIDTH-1:0]             b_eff;
   logic                         adv;
`ifdef ADDSUB_ZERO_FLAG_EN
   logic [STAGES-1:0]            zero_q, zero_d;
`endif

   always_comb begin
      adv      = ~valid_q[STAGES-1] | out_ready;
      b_eff    = sub ? ~b : b;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      valid_d  = valid_q;
      limb_sum = '0;
`ifdef ADDSUB_ZERO_FLAG_EN
      zero_d   = zero_q;
`endif

      limb_sum[0] = {1'b0, a[L-1:0]} + {1'b0, b_eff[L-1:0]} + {{L{1'b0}}, sub | cin};
      for (int k = 1; k < STAGES; k++) begin
         limb_sum[k] = {1'b0, a_q[k-1][k*L +: L]} + {1'b0, b_q[k-1][k*L +: L]}
                     + {{L{1'b0}}, carry_q[k-1]};
      end

      if (adv) begin
         acc_d[0]          = '0;
         acc_d[0][L-1:0]   = limb_sum[0][L-1:0];
         carry_d[0]        = limb_sum[0][L];
         a_d[0]            = a;
         b_d[0]            = b_eff;
         valid_d[0]        = in_valid;
`ifdef ADDSUB_ZERO_FLAG_EN
         // zero bit is gated with valid so the final flag needs no extra qualification
         zero_d[0]         = in_valid & ~|limb_sum[0][L-1:0];
`endif
         for (int k = 1; k < STAGES; k++) begin
            acc_d[k]           = acc_q[k-1];
            acc_d[k][k*L +: L] = limb_sum[k][L-1:0];
            carry_d[k]         = limb_sum[k][L];
            a_d[k]             = a_q[k-1];
            b_d[k]             = b_q[k-1];
            valid_d[k]         = valid_q[k-1];
`ifdef ADDSUB_ZERO_FLAG_EN
            zero_d[k]          = zero_q[k-1] & ~|limb_sum[k][L-1:0];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= '0;
         valid_q <= '0;
`ifdef ADDSUB_ZERO_FLAG_EN
         zero_q  <= '0;
`endif
      end else begin
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         valid_q <= valid_d;
`ifdef ADDSUB_ZERO_FLAG_EN
         zero_q  <= zero_d;
`endif
      end
   end

   assign in_ready  = adv;
   assign out_valid = valid_q[STAGES-1];
   assign result    = {carry_q[STAGES-1], acc_q[STAGES-1]};
`ifdef ADDSUB_ZERO_FLAG_EN
   assign result_zero = zero_q[STAGES-1];
`endif

   // consumed lower limbs and the last stage's operand copies are never read
   logic unused_skew;
   assign unused_skew = ^{a_q, b_q};

endmodule
